regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Sequential reader that walks the register file read port from x0 to x(REG_COUNT-1) on a start pulse.
- Streams each (index, value) pair out on a valid/ready channel for the debug/trace path and the testbench scoreboard.
- Sits beside the datapath and drives a dedicated read address into the register file; consumes the combinational read data.
- Counterpart of the register file's write side: it observes what the writers committed.

Parameters:
- DATA_WIDTH, 32, width of one register / stream data word
- ADDR_WIDTH, 5, width of register index
- REG_COUNT, 32, number of registers walked (indices 0..REG_COUNT-1)

Ports:
- CLK  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle request to begin a dump
- busy  output  1  high from the cycle after an accepted start until the done pulse
- done  output  1  one-cycle pulse after the final beat is accepted
- rd_addr  output  ADDR_WIDTH  read address to the register file read port
- rd_data  input  DATA_WIDTH  combinational read data for rd_addr
- m_valid  output  1  stream beat valid
- m_ready  input  1  stream sink ready
- m_addr  output  ADDR_WIDTH  register index of current beat
- m_data  output  DATA_WIDTH  register value of current beat
- m_last  output  1  marks final beat of the dump

Behaviour:
- Reset (async, rst=1): state IDLE; idx=0; busy=0, done=0, m_valid=0, m_last=0, m_addr=0, m_data=0; rd_addr=0.
- rd_addr is always driven from idx, so it is combinationally registered-index driven.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: on start=1, set idx=0 and go to READ. busy rises next cycle.
- READ (1 cycle): capture rd_data into m_data and idx into m_addr; set m_valid=1 and m_last=(idx==REG_COUNT-1); go to SEND.
- SEND: hold m_valid/m_addr/m_data/m_last stable until m_valid&&m_ready.
  - On the handshake with m_last=0: clear m_valid, increment idx, go to READ.
  - On the handshake with m_last=1: clear m_valid, go to DONE.
- DONE (1 cycle): done=1, busy=0 in that cycle; idx returns to 0; go to IDLE.
- Throughput: at most one beat per 2 cycles. A full dump with m_ready tied high takes 2*REG_COUNT+1 cycles from start to done.
- Snapshot rule: each value is sampled in its READ cycle. Writes to a register after its READ cycle are not reflected. Writes to a register before its READ cycle are reflected. Dump coherency is not guaranteed.
- start while busy (READ/SEND/DONE) is ignored; no queueing.
- m_ready high outside SEND has no effect. m_valid never drops without a handshake, except on reset.
- rst mid-dump: immediate abort to IDLE, outputs to reset values, no done pulse.
- x0 is read like any other index; its value is whatever the register file returns (expected 0).
- Arithmetic: idx is ADDR_WIDTH bits and never wraps, because the terminal condition is checked before incrementing.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of all captured words is kept, cleared on start.
  - After the beat for index REG_COUNT-1 is accepted (that beat now has m_last=0), one extra beat is emitted with m_addr = all-ones, m_data = XOR checksum and m_last=1.
  - An extra state, CSUM, sits between the final SEND and DONE.
  - Dump length is REG_COUNT+1 beats.
- Undefined: no checksum logic; exactly REG_COUNT beats; m_last on index REG_COUNT-1.

Decomposition:
- Shared package holds:
  - the FSM state encoding typedef (IDLE, READ, SEND, DONE, CSUM);
  - DUMP_CSUM_ADDR (all-ones index constant);
  - default DATA_WIDTH/ADDR_WIDTH/REG_COUNT constants, matching the register file.
- One natural sub-module: regfile_dump_csum, the XOR accumulator with clear and enable, instantiated only under the macro.
- Otherwise a single flat module.

Test Plan:
- Regfile preloaded with x5=6, x9=0x2004, others 0; start pulse; m_ready=1 → 32 beats in index order.
  - Beat 5 carries data 6; beat 9 carries 0x2004.
  - m_last only on addr 31; done 65 cycles after start; busy low afterwards.
- Same preload; m_ready toggles 1 cycle high / 3 low → each beat holds m_valid/m_addr/m_data stable while stalled; no beat dropped or duplicated.
- Write x20=0xDEADBEEF while idx=10, then x3=0x1234 during the same dump → beat 20 shows 0xDEADBEEF; beat 3 shows its old value 0.
- Assert rst while in SEND at idx=12 → outputs zero immediately, no done pulse. A new start afterwards dumps from index 0.
- Pulse start again at idx=7 → ignored; dump completes normally with one done pulse.
- With REGFILE_DUMP_CHECKSUM_EN and preload x5=6, x9=0x2004 → 33rd beat has m_addr=31 (all-ones), m_data=0x2002 (6 XOR 0x2004), m_last=1; beat 31 has m_last=0.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
// Holds the FSM state encoding, the checksum beat index and the default
// geometry, which matches the register file this block reads.
package regfile_dump_reader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_REG_COUNT  = 32;

  // Index carried by the trailing checksum beat (all ones)
  localparam logic [DEF_ADDR_WIDTH-1:0] DUMP_CSUM_ADDR = '1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3,
    ST_CSUM = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_csum.sv
// XOR accumulator over the words captured during one dump.
// clr has priority over en; both are synchronous, rst is asynchronous.
module regfile_dump_csum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] csum
);

  // Running XOR of every word presented with en
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (clr) begin
      csum <= '0;
    end else if (en) begin
      csum <= csum ^ din;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: on a start pulse walks x0..x(REG_COUNT-1)
// through a dedicated read port and streams (index, value) beats.
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN appends one extra beat
// (index all-ones, data = XOR of all captured words) as the last beat.
//
// Stream handshake: a beat transfers on a rising CLK edge where
// m_valid && m_ready. Once m_valid is high, m_addr/m_data/m_last stay
// stable and m_valid stays high until that transfer (only rst can drop it).
// m_ready may toggle freely and is ignored while m_valid is low.
//
// dbg_state exposes the FSM state for checkers and trace.
import regfile_dump_reader_pkg::*;

module regfile_dump_reader #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [2:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  dump_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;
  logic                  m_valid_nxt, m_last_nxt;
  logic [ADDR_WIDTH-1:0] m_addr_nxt;
  logic [DATA_WIDTH-1:0] m_data_nxt;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic                  csum_clr, csum_en;
  logic [DATA_WIDTH-1:0] csum_val;

  regfile_dump_csum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_csum (
    .CLK  (CLK),
    .rst  (rst),
    .clr  (csum_clr),
    .en   (csum_en),
    .din  (rd_data),
    .csum (csum_val)
  );
`endif

  // The read port always points at the current walk index
  assign rd_addr   = idx;
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  // State, index and registered stream outputs
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      m_valid <= m_valid_nxt;
      m_last  <= m_last_nxt;
      m_addr  <= m_addr_nxt;
      m_data  <= m_data_nxt;
    end
  end

  // Next-state and next-output decode; everything holds by default
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    m_valid_nxt = m_valid;
    m_last_nxt  = m_last;
    m_addr_nxt  = m_addr;
    m_data_nxt  = m_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_clr    = 1'b0;
    csum_en     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          state_nxt = ST_READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_clr  = 1'b1;
`endif
        end
      end
      ST_READ: begin
        // Snapshot point: the register value is sampled in this cycle
        m_valid_nxt = 1'b1;
        m_addr_nxt  = idx;
        m_data_nxt  = rd_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        m_last_nxt  = 1'b0;
        csum_en     = 1'b1;
`else
        m_last_nxt  = (idx == LAST_IDX);
`endif
        state_nxt   = ST_SEND;
      end
      ST_SEND: begin
        if (m_valid && m_ready) begin
          m_valid_nxt = 1'b0;
          if (m_last) begin
            state_nxt = ST_DONE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          end else if (idx == LAST_IDX) begin
            // Terminal index reached: idx is never incremented past it
            state_nxt = ST_CSUM;
`endif
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = ST_READ;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        m_valid_nxt = 1'b1;
        m_addr_nxt  = '1;
        m_data_nxt  = csum_val;
        m_last_nxt  = 1'b1;
        state_nxt   = ST_SEND;
      end
`endif
      ST_DONE: begin
        idx_nxt    = '0;
        m_last_nxt = 1'b0;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader with a scoreboard queue.
// Builds with or without REGFILE_DUMP_CHECKSUM_EN; expectations follow the macro.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RC = 32;
  localparam int W  = AW + DW + 1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int DUMP_LEN = RC + 1;
`else
  localparam int DUMP_LEN = RC;
`endif
  localparam int EXP_CYC = 2 * DUMP_LEN + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          CLK = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid, m_ready, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [2:0]    dbg_state;

  logic [DW-1:0] rf     [RC];
  logic [DW-1:0] exp_rf [RC];

  always #5 CLK = ~CLK;

  assign rd_data = rf[rd_addr];

  regfile_dump_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .REG_COUNT  (RC)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_last    (m_last),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           done_cnt = 0;
  int           ready_mode = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_beat = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_dump();
    logic [DW-1:0] x;
    logic          last;
    x = '0;
    for (int i = 0; i < RC; i++) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
      last = 1'b0;
`else
      last = (i == RC - 1);
`endif
      exp_q.push_back({AW'(i), exp_rf[i], last});
      x = x ^ exp_rf[i];
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    exp_q.push_back({DUMP_CSUM_ADDR, x, 1'b1});
`endif
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 1000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  task automatic wait_rd_addr(input int a);
    int n;
    n = 0;
    while (rd_addr != AW'(a) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check("reach_idx", rd_addr, a);
  endtask

  task automatic finish_dump(input string tag, input int d0, input bit check_lat);
    int cyc;
    wait_done(cyc);
    if (check_lat) check({tag, "_latency"}, cyc, EXP_CYC);
    @(posedge CLK); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus, monitor, report ----------------
  initial begin
    int d0;
    int phase;
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    phase = 0;
    for (int i = 0; i < RC; i++) rf[i] = '0;
    rf[5] = 32'd6;
    rf[9] = 32'h2004;
    for (int i = 0; i < RC; i++) exp_rf[i] = rf[i];

    fork
      // m_ready driver
      forever begin
        @(posedge CLK); #2;
        case (ready_mode)
          0: m_ready = 1'b1;
          1: begin
            m_ready = (phase == 0);
            phase = (phase + 1) % 4;
          end
          3: m_ready = 1'($urandom_range(0, 1));
          default: m_ready = 1'b0;
        endcase
      end
      // output monitor + scoreboard compare
      forever begin
        @(negedge CLK);
        if (rst) begin
          prev_stall = 1'b0;
        end else begin
          if (done) done_cnt++;
          if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_beat", {m_addr, m_data, m_last}, prev_beat);
          end
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
            else check("beat", {m_addr, m_data, m_last}, exp_q.pop_front());
          end
          prev_stall = m_valid && !m_ready;
          prev_beat  = {m_addr, m_data, m_last};
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_addr", m_addr, 0);
    check("rst_data", m_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // full dump, m_ready always high
    ready_mode = 0;
    push_dump();
    d0 = done_cnt;
    pulse_start();
    check("busy_rise", busy, 1);
    finish_dump("full", d0, 1'b1);

    // 1 high / 3 low backpressure
    ready_mode = 1;
    push_dump();
    d0 = done_cnt;
    pulse_start();
    finish_dump("stall", d0, 1'b0);

    // snapshot: x20 written before its READ, x3 after
    ready_mode = 0;
    exp_rf[20] = 32'hDEADBEEF;
    push_dump();
    d0 = done_cnt;
    pulse_start();
    wait_rd_addr(10);
    rf[20] = 32'hDEADBEEF;
    @(posedge CLK); #1;
    rf[3] = 32'h1234;
    finish_dump("snap", d0, 1'b0);
    for (int i = 0; i < RC; i++) exp_rf[i] = rf[i];

    // reset while stalled in SEND at idx 12
    push_dump();
    d0 = done_cnt;
    pulse_start();
    wait_rd_addr(12);
    ready_mode = 2;
    @(posedge CLK); #1;
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_addr", m_addr, 12);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", m_valid, 0);
    check("abort_addr", m_addr, 0);
    check("abort_data", m_data, 0);
    check("abort_busy", busy, 0);
    check("abort_rd_addr", rd_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    ready_mode = 0;
    push_dump();
    d0 = done_cnt;
    pulse_start();
    finish_dump("after_rst", d0, 1'b1);

    // start while busy is ignored
    push_dump();
    d0 = done_cnt;
    pulse_start();
    wait_rd_addr(7);
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    finish_dump("restart", d0, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    check("restart_idle_busy", busy, 0);
    check("restart_single_done", done_cnt - d0, 1);

    // random backpressure
    ready_mode = 3;
    push_dump();
    d0 = done_cnt;
    pulse_start();
    finish_dump("random", d0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
